// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master (write one byte or read one byte).
// Each bus bit occupies one slot of four phases P0..P3, CLK_DIV clocks each.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   start           - one-cycle request; rw_mode/address/write_data latched with it
//   sda_in          - SDA bus level (asynchronous, synchronized internally)
//   scl_out/sda_out - open-drain style drives: 1 = release, 0 = pull low
//   busy/done       - transaction in progress / one-cycle completion pulse
//   ack_error       - slave NACKed address or data byte; held until next start
//   read_data       - byte received by the last successful read
module i2c_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw_mode,
   input  logic [6:0] address,
   input  logic [7:0] write_data,
   input  logic       sda_in,
   output logic       scl_out,
   output logic       sda_out,
   output logic       busy,
   output logic       done,
   output logic       ack_error,
   output logic [7:0] read_data
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      START    = 4'd1,
      ADDR     = 4'd2,
      ADDR_ACK = 4'd3,
      TX       = 4'd4,
      TX_ACK   = 4'd5,
      RX       = 4'd6,
      RX_NACK  = 4'd7,
      STOP     = 4'd8,
      DONE     = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  abyte_q, abyte_d;   // {address, rw_mode}; bit 0 is the read flag
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rx_q, rx_d;
   logic        samp_q, samp_d;     // SDA level captured in the current slot
   logic        ack_err_q, ack_err_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        scl_q, scl_d;
   logic        sda_q, sda_d;
   logic        sync1_q, sync2_q;
   logic        cnt_last_s, slot_end_s, sample_s;

   // Bus line levels for a given position inside the transaction.
   function automatic logic [1:0] line_levels(input state_t st, input logic [1:0] ph,
                                              input logic [2:0] b, input logic [7:0] ab,
                                              input logic [7:0] wb);
      logic [1:0] lv;
      lv = 2'b11;
      case (st)
         IDLE, DONE:                    lv = 2'b11;
         START:                         lv = {1'b1, ~ph[1]};
         ADDR:                          lv = {ph[1], ab[b]};
         TX:                            lv = {ph[1], wb[b]};
         ADDR_ACK, TX_ACK, RX, RX_NACK: lv = {ph[1], 1'b1};
         STOP: begin
            case (ph)
               2'd0:    lv = 2'b00;
               2'd1:    lv = 2'b10;
               default: lv = 2'b11;
            endcase
         end
         default:                       lv = 2'b11;
      endcase
      return lv;
   endfunction

   assign cnt_last_s = (cnt_q == 8'(CLK_DIV - 1));
   assign slot_end_s = cnt_last_s && (phase_q == 2'd3);
   assign sample_s   = cnt_last_s && (phase_q == 2'd2);

   // Next-state, bit sequencing and output decode.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      abyte_d   = abyte_q;
      wdata_d   = wdata_q;
      rx_d      = rx_q;
      ack_err_d = ack_err_q;
      rdata_d   = rdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      samp_d    = sample_s ? sync2_q : samp_q;

      // Phase timing only runs while bus slots are being generated.
      if ((state_q != IDLE) && (state_q != DONE)) begin
         if (cnt_last_s) begin
            cnt_d   = 8'd0;
            phase_d = phase_q + 2'd1;
         end else begin
            cnt_d   = cnt_q + 8'd1;
         end
      end else begin
         cnt_d   = 8'd0;
         phase_d = 2'd0;
      end

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               abyte_d   = {address, rw_mode};
               wdata_d   = write_data;
               ack_err_d = 1'b0;
               busy_d    = 1'b1;
               bit_d     = 3'd7;
               state_d   = START;
            end else begin
               state_d   = IDLE;
            end
         end
         START: begin
            if (slot_end_s) begin
               bit_d   = 3'd7;
               state_d = ADDR;
            end else begin
               state_d = START;
            end
         end
         ADDR, TX, RX: begin
            if (state_q == RX && sample_s) begin
               rx_d = {rx_q[6:0], sync2_q};
            end else begin
               rx_d = rx_q;
            end
            if (slot_end_s) begin
               if (bit_q == 3'd0) begin
                  case (state_q)
                     ADDR:    state_d = ADDR_ACK;
                     TX:      state_d = TX_ACK;
                     default: state_d = RX_NACK;
                  endcase
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end else begin
               bit_d = bit_q;
            end
         end
         ADDR_ACK: begin
            if (slot_end_s) begin
               bit_d = 3'd7;
               if (samp_q) begin
                  ack_err_d = 1'b1;
                  state_d   = STOP;
               end else if (abyte_q[0]) begin
                  state_d   = RX;
               end else begin
                  state_d   = TX;
               end
            end else begin
               state_d = ADDR_ACK;
            end
         end
         TX_ACK, RX_NACK: begin
            if (slot_end_s) begin
               // Only the write path's ninth bit is a slave acknowledge.
               if (state_q == TX_ACK && samp_q) begin
                  ack_err_d = 1'b1;
               end else begin
                  ack_err_d = ack_err_q;
               end
               state_d = STOP;
            end else begin
               state_d = state_q;
            end
         end
         STOP: begin
            if (slot_end_s) begin
               done_d  = 1'b1;
               state_d = DONE;
               if (abyte_q[0] && !ack_err_q) begin
                  rdata_d = rx_q;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = STOP;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Lines are decoded from the next position so the registered drives line up with the state.
      {scl_d, sda_d} = line_levels(state_d, phase_d, bit_d, abyte_d, wdata_d);
   end

   // State, datapath and registered output update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= 2'd0;
         cnt_q     <= 8'd0;
         bit_q     <= 3'd0;
         abyte_q   <= 8'h00;
         wdata_q   <= 8'h00;
         rx_q      <= 8'h00;
         samp_q    <= 1'b1;
         ack_err_q <= 1'b0;
         rdata_q   <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         scl_q     <= 1'b1;
         sda_q     <= 1'b1;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         abyte_q   <= abyte_d;
         wdata_q   <= wdata_d;
         rx_q      <= rx_d;
         samp_q    <= samp_d;
         ack_err_q <= ack_err_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         sync1_q   <= sda_in;
         sync2_q   <= sync1_q;
      end
   end

   assign scl_out   = scl_q;
   assign sda_out   = sda_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ack_error = ack_err_q;
   assign read_data = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench for i2c_master (CLK_DIV = 2).
// A behavioural slave drives ACK/NACK and read bits on SCL falling edges.
// Stimulus pushes expected results into a queue; a monitor captures the bus
// bits, START/STOP conditions and done, and pops/compares on each done.
module tb_i2c_master;

   localparam int unsigned DIV = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rw_mode;
   logic [6:0] address;
   logic [7:0] write_data;
   logic       sda_in;
   logic       scl_out;
   logic       sda_out;
   logic       busy;
   logic       done;
   logic       ack_error;
   logic [7:0] read_data;

   logic       slave_sda = 1'b1;
   logic       sda_bus;
   assign sda_bus = sda_out & slave_sda;
   assign sda_in  = sda_bus;

   i2c_master #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .rw_mode(rw_mode),
      .address(address), .write_data(write_data), .sda_in(sda_in),
      .scl_out(scl_out), .sda_out(sda_out), .busy(busy), .done(done),
      .ack_error(ack_error), .read_data(read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         acc;
      int         lat;
      logic       ackerr;
      logic [7:0] rdata;
      logic [7:0] abyte;
      logic       ack1;
      logic [7:0] dbyte;
      logic       ack2;
      bit         full;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // slave configuration for the current transaction
   logic       sl_read = 1'b0;
   logic       sl_nack_addr = 1'b0;
   logic       sl_nack_data = 1'b0;
   logic [7:0] sl_rbyte = 8'h00;
   int         fall_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Slave: the n-th SCL fall opens slot n (1..8 address, 9 ack, 10..17 data, 18 ack).
   initial forever begin
      @(negedge scl_out);
      fall_cnt = fall_cnt + 1;
      if (fall_cnt == 9)
         slave_sda = sl_nack_addr;
      else if (!sl_nack_addr && !sl_read && fall_cnt == 18)
         slave_sda = sl_nack_data;
      else if (!sl_nack_addr && sl_read && fall_cnt >= 10 && fall_cnt <= 17)
         slave_sda = sl_rbyte[17 - fall_cnt];
      else
         slave_sda = 1'b1;
   end

   // Monitor: capture bits at SCL rise, count START/STOP, score on done.
   initial begin
      logic       scl_prev, sda_prev, done_prev;
      logic [7:0] cap_a, cap_d;
      logic       cap_k1, cap_k2;
      int         rise_cnt, starts, stops;
      exp_t       e;
      scl_prev = 1'b1; sda_prev = 1'b1; done_prev = 1'b0;
      cap_a = 8'h00; cap_d = 8'h00; cap_k1 = 1'b0; cap_k2 = 1'b0;
      rise_cnt = 0; starts = 0; stops = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rise_cnt = 0; starts = 0; stops = 0; done_prev = 1'b0;
         end else begin
            if (done_prev) begin
               chk("done_one_cycle", done, 1'b0);
               chk("busy_low_after_done", busy, 1'b0);
            end
            if (!scl_prev && scl_out) begin
               rise_cnt++;
               if (rise_cnt <= 8)       cap_a = {cap_a[6:0], sda_bus};
               else if (rise_cnt == 9)  cap_k1 = sda_bus;
               else if (rise_cnt <= 17) cap_d = {cap_d[6:0], sda_bus};
               else if (rise_cnt == 18) cap_k2 = sda_bus;
            end
            if (scl_prev && scl_out && sda_prev && !sda_bus) starts++;
            if (scl_prev && scl_out && !sda_prev && sda_bus) stops++;
            if (done) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: done seen at cycle %0d with nothing expected", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("latency", cyc - e.acc, e.lat);
                  chk("ack_error", ack_error, e.ackerr);
                  chk("read_data", read_data, e.rdata);
                  chk("addr_byte", cap_a, e.abyte);
                  chk("addr_ack_bit", cap_k1, e.ack1);
                  chk("start_cond_count", starts, 1);
                  chk("stop_cond_count", stops, 1);
                  if (e.full) begin
                     chk("data_byte", cap_d, e.dbyte);
                     chk("data_ack_bit", cap_k2, e.ack2);
                  end
               end
               rise_cnt = 0; starts = 0; stops = 0;
            end
            done_prev = done;
         end
         scl_prev = scl_out;
         sda_prev = sda_bus;
      end
   end

   // Issue a start at a negedge; optionally push the expected outcome.
   task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                        input logic nack_a, input logic nack_d, input logic [7:0] rb,
                        input bit push, input int lat, input logic eerr, input logic [7:0] erd);
      exp_t e;
      sl_read = rw; sl_nack_addr = nack_a; sl_nack_data = nack_d; sl_rbyte = rb;
      fall_cnt = 0; slave_sda = 1'b1;
      rw_mode = rw; address = a; write_data = wd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rw_mode = ~rw; address = ~a; write_data = ~wd;
      if (push) begin
         e.acc = cyc; e.lat = lat; e.ackerr = eerr; e.rdata = erd;
         e.abyte = {a, rw}; e.ack1 = nack_a;
         e.dbyte = rw ? rb : wd;
         e.ack2  = rw ? 1'b1 : nack_d;
         e.full  = !nack_a;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((busy || done) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy || done) begin
         checks++; errors++;
         $display("FAIL %s: timeout waiting for idle, busy=%0b", nm, busy);
      end
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s: timeout waiting for done", nm);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rw_mode = 1'b0; address = 7'h00; write_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_scl", scl_out, 1'b1);
      chk("rst_sda", sda_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ack_error", ack_error, 1'b0);
      chk("rst_read_data", read_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // write 0x48 <- 0xA5, with a stray start while busy that must be ignored
      issue(1'b0, 7'h48, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 80 * DIV, 1'b0, 8'h00);
      repeat (30) @(negedge clk);
      rw_mode = 1'b1; address = 7'h11; write_data = 8'h0F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("write_a5");

      // read 0x23 -> 0x3C, then a start pulse coincident with done
      issue(1'b1, 7'h23, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 80 * DIV, 1'b0, 8'h3C);
      wait_done("read_3c");
      rw_mode = 1'b0; address = 7'h10; write_data = 8'h99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("start_at_done_ignored", busy, 1'b0);

      // address NACK: short transaction, read_data keeps 0x3C
      issue(1'b0, 7'h50, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 44 * DIV, 1'b1, 8'h3C);
      wait_idle("addr_nack");

      // data NACK at extreme address/data values
      issue(1'b0, 7'h7F, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 80 * DIV, 1'b1, 8'h3C);
      wait_idle("data_nack");

      // abort mid-TX with reset
      issue(1'b0, 7'h48, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_scl", scl_out, 1'b1);
      chk("abort_sda", sda_out, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_read_data", read_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // fresh write after abort
      issue(1'b0, 7'h48, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 80 * DIV, 1'b0, 8'h00);
      wait_idle("write_after_abort");

      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d transactions never completed, expected 0", exp_q.size());
      end
      repeat (50) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
